// File: rtl/inst_cache.sv
// inst_cache: direct-mapped, one-word-per-line instruction cache refilled byte-wise from the memory arbiter.
// Defining ICACHE_STATS_EN adds the _hit_cnt/_miss_cnt counters.
module inst_cache #(
  parameter int INDEX_BITS = 5
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        _need_inst,
  input  logic [31:0] _pc,
  output logic        _inst_ready,
  output logic [31:0] _inst,
  output logic        _busy,
  output logic        _mem_rd_req,
  output logic [31:0] _mem_rd_addr,
  input  logic        _mem_rd_valid,
  input  logic [7:0]  _mem_rd_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] _hit_cnt,
  output logic [31:0] _miss_cnt
`endif
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;
  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;
  state_t                  state;
  logic [1:0]              cnt;
  logic                    cancel;
  logic [TAG_W-1:0]        fill_tag;
  logic [INDEX_BITS-1:0]   fill_idx;
  logic [23:0]             fill_buf;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tag_arr [LINES];
  logic [31:0]             data_arr [LINES];
  logic [TAG_W-1:0]        req_tag;
  logic [INDEX_BITS-1:0]   req_idx;
  logic                    hit, accept, fill_done, unused_pc_lo;
  logic [31:0]             fill_word;
  assign req_tag      = _pc[31:INDEX_BITS+2];
  assign req_idx      = _pc[INDEX_BITS+1:2];
  assign unused_pc_lo = ^_pc[1:0];
  assign hit          = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign accept       = (state == IDLE) && _need_inst && !_clear;
  assign fill_done    = (state == REFILL) && _mem_rd_valid && (cnt == 2'd3);
  assign fill_word    = {_mem_rd_data, fill_buf};
  assign _busy        = state != IDLE;
  assign _mem_rd_req  = state == REFILL;
  assign _mem_rd_addr = {fill_tag, fill_idx, 2'b00};
  // Reset forces state to IDLE, so an abandoned fill can never reach this write
  always_ff @(posedge clk_in)
    if (rdy_in && fill_done) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= fill_word;
    end
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      cancel      <= 1'b0;
      fill_tag    <= '0;
      fill_idx    <= '0;
      fill_buf    <= '0;
      valid       <= '0;
      _inst_ready <= 1'b0;
      _inst       <= '0;
`ifdef ICACHE_STATS_EN
      _hit_cnt    <= '0;
      _miss_cnt   <= '0;
`endif
    end else if (rdy_in) begin
      _inst_ready <= 1'b0;
      if (state == IDLE) begin
        cancel <= 1'b0;
        if (accept && hit) begin
          _inst_ready <= 1'b1;
          _inst       <= data_arr[req_idx];
`ifdef ICACHE_STATS_EN
          _hit_cnt    <= _hit_cnt + 32'd1;
`endif
        end else if (accept) begin
          state    <= REFILL;
          fill_tag <= req_tag;
          fill_idx <= req_idx;
          cnt      <= 2'd0;
`ifdef ICACHE_STATS_EN
          _miss_cnt <= _miss_cnt + 32'd1;
`endif
        end
      end else if (state == REFILL) begin
        if (_clear) cancel <= 1'b1;
        if (_mem_rd_valid) begin
          cnt      <= cnt + 2'd1;
          fill_buf <= {_mem_rd_data, fill_buf[23:8]};
          if (cnt == 2'd3) begin
            valid[fill_idx] <= 1'b1;
            state           <= RESP;
            _inst_ready     <= !(cancel || _clear);
            if (!(cancel || _clear)) _inst <= fill_word;
          end
        end
      end else begin
        cancel <= 1'b0;
        state  <= IDLE;
      end
    end
endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: directed-vector bench for inst_cache with hand-computed expectations.
module tb_inst_cache;
  logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, clr = 1'b0, need = 1'b0, mem_valid = 1'b0;
  logic [31:0] pc = '0;
  logic [7:0]  mem_data = '0;
  logic        inst_ready, busy, mem_req;
  logic [31:0] inst, mem_addr;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif
  int n_cmp = 0, n_err = 0;
  inst_cache dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(clr), ._need_inst(need), ._pc(pc),
    ._inst_ready(inst_ready), ._inst(inst), ._busy(busy), ._mem_rd_req(mem_req), ._mem_rd_addr(mem_addr),
    ._mem_rd_valid(mem_valid), ._mem_rd_data(mem_data)
`ifdef ICACHE_STATS_EN
    , ._hit_cnt(hit_cnt), ._miss_cnt(miss_cnt)
`endif
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask
  task automatic fetch(input logic [31:0] a);
    need = 1'b1;
    pc   = a;
    step();
    need = 1'b0;
  endtask
  task automatic feed(input logic [31:0] w, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      mem_valid = 1'b1;
      mem_data  = w[8*i +: 8];
      step();
    end
    mem_valid = 1'b0;
  endtask
  initial begin
    #2;
    chk("rst_ready", inst_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_inst", inst, 0);
    step();
    rst_in = 1'b1;
    step();
    // cold miss
    fetch(32'h0);
    chk("s1_busy", busy, 1);
    chk("s1_req", mem_req, 1);
    chk("s1_addr", mem_addr, 32'h0);
    chk("s1_rdy0", inst_ready, 0);
    feed(32'h13, 0, 3);
    chk("s1_early", inst_ready, 0);
    feed(32'h13, 3, 4);
    chk("s1_ready", inst_ready, 1);
    chk("s1_inst", inst, 32'h13);
    chk("s1_req_drop", mem_req, 0);
    chk("s1_busy_resp", busy, 1);
    step();
    chk("s1_idle_busy", busy, 0);
    chk("s1_single", inst_ready, 0);
    // re-fetch hit
    fetch(32'h0);
    chk("s2_ready", inst_ready, 1);
    chk("s2_inst", inst, 32'h13);
    chk("s2_req", mem_req, 0);
    chk("s2_busy", busy, 0);
    step();
    chk("s2_single", inst_ready, 0);
`ifdef ICACHE_STATS_EN
    chk("s6_hits", hit_cnt, 1);
    chk("s6_miss", miss_cnt, 1);
`endif
    // conflict on index 0
    fetch(32'h80);
    chk("s3_req", mem_req, 1);
    chk("s3_addr", mem_addr, 32'h80);
    feed(32'hFFF00093, 0, 4);
    chk("s3_ready", inst_ready, 1);
    chk("s3_inst", inst, 32'hFFF00093);
    step();
    fetch(32'h0);
    chk("s3_remiss", mem_req, 1);
    chk("s3_readdr", mem_addr, 32'h0);
    feed(32'h13, 0, 4);
    chk("s3_reinst", inst, 32'h13);
    step();
    // back-to-back hits
    need = 1'b1;
    pc   = 32'h0;
    step();
    chk("b2b_1", inst_ready, 1);
    step();
    chk("b2b_2", inst_ready, 1);
    need = 1'b0;
    step();
    chk("b2b_end", inst_ready, 0);
    // clear in IDLE drops the request
    need = 1'b1;
    clr  = 1'b1;
    step();
    need = 1'b0;
    clr  = 1'b0;
    chk("clr_idle_rdy", inst_ready, 0);
    chk("clr_idle_busy", busy, 0);
    // clear mid-refill
    fetch(32'h4);
    chk("s4_addr", mem_addr, 32'h4);
    feed(32'h44332211, 0, 2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("s4_busy", busy, 1);
    feed(32'h44332211, 2, 4);
    chk("s4_nopulse", inst_ready, 0);
    chk("s4_inst_hold", inst, 32'h13);
    step();
    chk("s4_idle", busy, 0);
    fetch(32'h4);
    chk("s4_hit", inst_ready, 1);
    chk("s4_inst", inst, 32'h44332211);
    chk("s4_noreq", mem_req, 0);
    // fill bytes outside REFILL are ignored
    mem_valid = 1'b1;
    mem_data  = 8'h55;
    step();
    step();
    mem_valid = 1'b0;
    chk("stray_busy", busy, 0);
    chk("stray_req", mem_req, 0);
    // pause mid-refill; clear while paused must not register
    fetch(32'hC);
    feed(32'hDDCCBBAA, 0, 1);
    rdy_in = 1'b0;
    clr    = 1'b1;
    step();
    step();
    step();
    chk("pause_req", mem_req, 1);
    chk("pause_busy", busy, 1);
    rdy_in = 1'b1;
    clr    = 1'b0;
    feed(32'hDDCCBBAA, 1, 4);
    chk("pause_ready", inst_ready, 1);
    chk("pause_inst", inst, 32'hDDCCBBAA);
    step();
    // reset mid-refill
    fetch(32'h10);
    feed(32'h12345678, 0, 3);
    rst_in = 1'b0;
    #1;
    chk("s5_req", mem_req, 0);
    chk("s5_busy", busy, 0);
    step();
    rst_in = 1'b1;
    step();
    fetch(32'h10);
    chk("s5_remiss", mem_req, 1);
    chk("s5_addr", mem_addr, 32'h10);
    feed(32'h12345678, 0, 4);
    chk("s5_inst", inst, 32'h12345678);
    step();
    fetch(32'h0);
    chk("s5_inval", mem_req, 1);
    feed(32'h13, 0, 4);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
